fp8_skew_feeder: RTL and testbench

// - Upstream edge feeder for the FP8 E4M3 systolic PE array. Accepts one N-lane FP8 vector per cycle over

---
 rtl/fp8_skew_feeder.sv | 151 +++++++++++++++
 tb/tb_fp8_skew_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_skew_feeder.sv
// fp8_skew_feeder: edge feeder for the FP8 E4M3 systolic array.
// Accepts one N-lane vector per cycle, skews lane i by i extra cycles,
// injects a per-lane tile clear, flushes skew + PE latency after the last
// vector and pulses tile_done when the PE results are stable.
module fp8_skew_feeder #(
  parameter int N           = 4,
  parameter int FLUSH_EXTRA = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*8-1:0]   in_data,
  input  logic             in_last,
  output logic [N*8-1:0]   lane_out,
  output logic [N-1:0]     clear_out,
  output logic             busy,
  output logic             tile_done,
  output logic [CNT_W-1:0] tile_len
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // FLUSH lasts N-1+FLUSH_EXTRA cycles so tile_done lands N+FLUSH_EXTRA
  // cycles after the last accept; the counter is loaded one below that
  // because the cycle in which it reads 0 is the final FLUSH cycle.
  localparam int FLUSH_CYCLES = N - 1 + FLUSH_EXTRA;
  localparam int FLUSH_LOAD_I = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam int FCNT_W       = (FLUSH_LOAD_I > 0) ? $clog2(FLUSH_LOAD_I + 1) : 1;
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_LOAD_I);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [FCNT_W-1:0]   flush_q, flush_d;
  logic                done_q, done_d;
  logic [N-1:0]        clr_q;
  logic                accept;
  logic                first_acc;
  logic [CNT_W-1:0]    cnt_inc;

  // Next-state, counters and handshake derived from the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    flush_d   = flush_q;
    done_d    = 1'b0;
    first_acc = 1'b0;
    in_ready  = (state_q != FLUSH);
    busy      = (state_q != IDLE);
    accept    = in_valid & in_ready;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    case (state_q)
      IDLE: begin
        if (accept) begin
          first_acc = 1'b1;
          cnt_d     = CNT_ONE;
          if (in_last) begin
            state_d = FLUSH;
            flush_d = FLUSH_LOAD;
            len_d   = CNT_ONE;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d = FLUSH;
            flush_d = FLUSH_LOAD;
            len_d   = cnt_inc;
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q - FCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset drops any tile in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  // Clear chain: stage i feeds lane i, so each clear meets element 0 of its lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q <= '0;
    end else begin
      for (int k = N - 1; k > 0; k--) begin
        clr_q[k] <= clr_q[k-1];
      end
      clr_q[0] <= first_acc;
    end
  end

  // Per-lane delay line of 1+gi stages; bubbles enter as FP8 zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [7:0] stage_q [0:gi];

    // Shift the lane's data one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= gi; k++) begin
          stage_q[k] <= 8'h00;
        end
      end else begin
        stage_q[0] <= accept ? in_data[8*gi +: 8] : 8'h00;
        for (int k = 1; k <= gi; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign lane_out[8*gi +: 8] = stage_q[gi];
  end

  assign clear_out = clr_q;
  assign tile_done = done_q;
  assign tile_len  = len_q;

endmodule

// File: tb/tb_fp8_skew_feeder.sv
// tb_fp8_skew_feeder: directed literal checks plus randomized traffic
// compared every cycle against a timeline model of the feeder.
module tb_fp8_skew_feeder;
  localparam int N    = 4;
  localparam int FE   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HIST = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [31:0]   lane_out;
  logic [3:0]    clear_out;
  logic          busy;
  logic          tile_done;
  logic [CW-1:0] tile_len;

  fp8_skew_feeder #(.N(N), .FLUSH_EXTRA(FE), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .lane_out  (lane_out),
    .clear_out (clear_out),
    .busy      (busy),
    .tile_done (tile_done),
    .tile_len  (tile_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: history of accepts by cycle plus tile timeline.
  int          rst_cyc   = -1;
  int          t_last    = -1000;
  int          count     = 0;
  int          model_len = 0;
  bit          tile_open = 1'b0;
  logic        acc_hist   [HIST];
  logic        first_hist [HIST];
  logic [31:0] data_hist  [HIST];

  logic        m_ready, m_busy, m_done, m_flush, m_acc;
  logic [31:0] m_lane;
  logic [3:0]  m_clr;
  int          m_k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if (rst) begin
      rst_cyc   = cyc;
      t_last    = -1000;
      tile_open = 1'b0;
      count     = 0;
      model_len = 0;
    end else if (cyc < HIST) begin
      m_flush = (cyc > t_last) && (cyc <= t_last + N - 1 + FE);
      m_done  = (cyc == t_last + N + FE);
      m_ready = !m_flush;
      m_busy  = tile_open || m_flush;
      m_lane  = '0;
      m_clr   = '0;
      for (int i = 0; i < N; i++) begin
        m_k = cyc - 1 - i;
        if (m_k > rst_cyc && m_k >= 0) begin
          if (acc_hist[m_k]) m_lane[8*i +: 8] = data_hist[m_k][8*i +: 8];
          if (first_hist[m_k]) m_clr[i] = 1'b1;
        end
      end
      chk("in_ready",  32'(in_ready),  32'(m_ready));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("tile_done", 32'(tile_done), 32'(m_done));
      chk("tile_len",  32'(tile_len),  32'(model_len));
      chk("lane_out",  lane_out,       m_lane);
      chk("clear_out", 32'(clear_out), 32'(m_clr));
      if (m_done) $display("tile done at cycle %0d, tile_len %0d", cyc, model_len);

      m_acc            = in_valid && m_ready;
      acc_hist[cyc]    = m_acc;
      data_hist[cyc]   = in_data;
      first_hist[cyc]  = m_acc && !tile_open;
      if (m_acc) begin
        if (!tile_open) begin
          count     = 1;
          tile_open = 1'b1;
        end else if (count < CMAX) begin
          count++;
        end
        if (in_last) begin
          t_last    = cyc;
          model_len = count;
          tile_open = 1'b0;
        end
      end
    end
  end

  // Drive one cycle's inputs, then move to just after the next edge.
  task automatic put(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'b0;
  endtask

  logic [31:0] exp_lane;
  logic [3:0]  exp_clr;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Skew of a single-vector tile, literal lane/clear pattern.
    repeat (4) put(1'b0, $urandom, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h44332211;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      idle_in();
      @(negedge clk);
      case (k)
        1:       begin exp_lane = 32'h00000011; exp_clr = 4'b0001; end
        2:       begin exp_lane = 32'h00002200; exp_clr = 4'b0010; end
        3:       begin exp_lane = 32'h00330000; exp_clr = 4'b0100; end
        4:       begin exp_lane = 32'h44000000; exp_clr = 4'b1000; end
        default: begin exp_lane = 32'h00000000; exp_clr = 4'b0000; end
      endcase
      chk("skew_lane",  lane_out, exp_lane);
      chk("skew_clear", 32'(clear_out), 32'(exp_clr));
      chk("skew_ready", 32'(in_ready), 32'(k == 6));
      chk("skew_done",  32'(tile_done), 32'(k == 6));
      if (k == 6) chk("skew_len", 32'(tile_len), 32'd1);
      @(posedge clk);
      #1;
    end

    // Three-vector tile, then a back-to-back single-vector tile.
    repeat (3) put(1'b0, $urandom, 1'b0);
    put(1'b1, $urandom, 1'b0);
    put(1'b1, $urandom, 1'b0);
    put(1'b1, $urandom, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        in_valid = 1'b1;
        in_data  = $urandom | 32'h00000001;
        in_last  = 1'b1;
      end else begin
        idle_in();
      end
      @(negedge clk);
      chk("t3_ready", 32'(in_ready), 32'(k == 6));
      chk("t3_done",  32'(tile_done), 32'(k == 6));
      chk("t3_busy",  32'(busy), 32'(k != 6));
      if (k == 6) chk("t3_len", 32'(tile_len), 32'd3);
      @(posedge clk);
      #1;
    end
    for (int k = 1; k <= 6; k++) begin
      idle_in();
      @(negedge clk);
      if (k == 1) chk("b2b_clear0", 32'(clear_out[0]), 32'd1);
      chk("b2b_done", 32'(tile_done), 32'(k == 6));
      if (k == 6) chk("b2b_len", 32'(tile_len), 32'd1);
      @(posedge clk);
      #1;
    end

    // Bubbles inside a tile keep it streaming.
    put(1'b1, $urandom, 1'b0);
    put(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle_in();
      @(negedge clk);
      chk("bub_busy",  32'(busy), 32'd1);
      chk("bub_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    put(1'b1, $urandom, 1'b1);
    repeat (5) put(1'b0, $urandom, 1'b0);
    idle_in();
    @(negedge clk);
    chk("bub_done", 32'(tile_done), 32'd1);
    chk("bub_len",  32'(tile_len), 32'd3);
    @(posedge clk);
    #1;

    // Vector count saturates at 2^CW-1.
    repeat (19) put(1'b1, $urandom, 1'b0);
    put(1'b1, $urandom, 1'b1);
    repeat (5) put(1'b0, $urandom, 1'b0);
    idle_in();
    @(negedge clk);
    chk("sat_done", 32'(tile_done), 32'd1);
    chk("sat_len",  32'(tile_len), 32'(CMAX));
    @(posedge clk);
    #1;

    // Abort two cycles into FLUSH with an asynchronous reset.
    repeat (2) put(1'b0, $urandom, 1'b0);
    put(1'b1, $urandom | 32'h01010101, 1'b0);
    put(1'b1, $urandom | 32'h01010101, 1'b1);
    put(1'b0, $urandom, 1'b0);
    idle_in();
    #1;
    rst = 1'b1;
    #1;
    chk("abort_lane",  lane_out, 32'd0);
    chk("abort_clear", 32'(clear_out), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(tile_done), 32'd0);
    chk("abort_len",   32'(tile_len), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) put(1'b0, $urandom, 1'b0);

    // Random traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        idle_in();
        #1;
        rst = 1'b1;
        #1;
        chk("rnd_rst_lane",  lane_out, 32'd0);
        chk("rnd_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      put(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0));
    end
    repeat (12) put(1'b0, $urandom, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
